// File: rtl/gpio_bank.sv
// GPIO bank with a pipelined Wishbone slave: output register, debounced inputs,
// rising-edge status flags (write-1-to-clear) and a level interrupt.
module gpio_bank #(
    parameter int NB_OUTPUTS      = 2,
    parameter int NB_INPUTS       = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    output logic [NB_OUTPUTS-1:0] gpio_o,
    input  logic [NB_INPUTS-1:0]  gpio_i,
    output logic                  irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    logic [NB_OUTPUTS-1:0] out_r;
    logic [NB_INPUTS-1:0]  in_r;
    logic [NB_INPUTS-1:0]  status_r;
    logic [NB_INPUTS-1:0]  irqen_r;
    logic [NB_INPUTS-1:0]  sync1_r;
    logic [NB_INPUTS-1:0]  sync2_r;
    logic [CW-1:0]         cnt_r [NB_INPUTS];
    logic                  ack_r;
    logic [31:0]           dat_r;
    logic                  irq_r;

    logic                  req_s;
    logic                  wr_s;
    logic [1:0]            adr_s;
    logic [31:0]           mask_s;
    logic [NB_OUTPUTS-1:0] out_next_s;
    logic [NB_INPUTS-1:0]  irqen_next_s;
    logic [NB_INPUTS-1:0]  in_next_s;
    logic [NB_INPUTS-1:0]  rise_s;
    logic [NB_INPUTS-1:0]  clr_s;
    logic [NB_INPUTS-1:0]  status_next_s;
    logic [CW-1:0]         cnt_next_s [NB_INPUTS];
    logic [31:0]           rdata_s;
    logic                  unused_s;

    assign req_s    = wb_cyc_i & wb_stb_i;
    assign wr_s     = req_s & wb_we_i;
    assign adr_s    = wb_adr_i[3:2];
    assign mask_s   = lane_mask(wb_sel_i);
    assign unused_s = ^{wb_adr_i, wb_dat_i, mask_s};

    // Per-bit debounce: count mismatching cycles, accept on the last one
    always_comb begin
        for (int i = 0; i < NB_INPUTS; i++) begin
            in_next_s[i]  = in_r[i];
            cnt_next_s[i] = {CW{1'b0}};
            if (sync2_r[i] != in_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    in_next_s[i]  = sync2_r[i];
                    cnt_next_s[i] = {CW{1'b0}};
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CW'(1);
                end
            end else begin
                cnt_next_s[i] = {CW{1'b0}};
            end
        end
        rise_s = in_next_s & ~in_r;
    end

    // Register write decode with byte-lane masking; a new edge beats a clear
    always_comb begin
        out_next_s   = out_r;
        irqen_next_s = irqen_r;
        clr_s        = {NB_INPUTS{1'b0}};
        if (wr_s) begin
            case (adr_s)
                2'd0: out_next_s = (out_r & ~mask_s[NB_OUTPUTS-1:0])
                                 | (wb_dat_i[NB_OUTPUTS-1:0] & mask_s[NB_OUTPUTS-1:0]);
                2'd2: clr_s = wb_dat_i[NB_INPUTS-1:0] & mask_s[NB_INPUTS-1:0];
                2'd3: irqen_next_s = (irqen_r & ~mask_s[NB_INPUTS-1:0])
                                   | (wb_dat_i[NB_INPUTS-1:0] & mask_s[NB_INPUTS-1:0]);
                default: out_next_s = out_r;
            endcase
        end else begin
            clr_s = {NB_INPUTS{1'b0}};
        end
        status_next_s = (status_r & ~clr_s) | rise_s;
    end

    // Read mux over pre-update register state
    always_comb begin
        rdata_s = 32'd0;
        case (adr_s)
            2'd0:    rdata_s[NB_OUTPUTS-1:0] = out_r;
            2'd1:    rdata_s[NB_INPUTS-1:0]  = in_r;
            2'd2:    rdata_s[NB_INPUTS-1:0]  = status_r;
            2'd3:    rdata_s[NB_INPUTS-1:0]  = irqen_r;
            default: rdata_s = 32'd0;
        endcase
    end

    // State, synchroniser and bus response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_r    <= {NB_OUTPUTS{1'b0}};
            in_r     <= {NB_INPUTS{1'b0}};
            status_r <= {NB_INPUTS{1'b0}};
            irqen_r  <= {NB_INPUTS{1'b0}};
            sync1_r  <= {NB_INPUTS{1'b0}};
            sync2_r  <= {NB_INPUTS{1'b0}};
            for (int i = 0; i < NB_INPUTS; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
            ack_r    <= 1'b0;
            dat_r    <= 32'd0;
            irq_r    <= 1'b0;
        end else begin
            out_r    <= out_next_s;
            in_r     <= in_next_s;
            status_r <= status_next_s;
            irqen_r  <= irqen_next_s;
            sync1_r  <= gpio_i;
            sync2_r  <= sync1_r;
            for (int i = 0; i < NB_INPUTS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            ack_r    <= req_s;
            dat_r    <= (req_s && !wb_we_i) ? rdata_s : 32'd0;
            irq_r    <= |(status_r & irqen_r);
        end
    end

    // A reset arriving in the ack cycle suppresses that ack immediately
    assign wb_ack_o   = ack_r & ~rst_i;
    assign wb_dat_o   = rst_i ? 32'd0 : dat_r;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_r;
    assign irq_o      = irq_r;

endmodule
